// File: rtl/ifu_pcgen_if.sv
// ifu_pcgen_if
// Bundles the fetch-side signals of ifu_pcgen:
//   branch resolution : bmu_vld, ifetch_taken, ifetch_taken_pc
//   imem request      : imem_req_vld, imem_req_rdy, imem_req_addr
//   imem response     : imem_rsp_vld, imem_rsp_data
//   decode handoff    : inst_vld, inst_rdy, inst, inst_pc
// master = the PC generator, slave = its environment (execute, memory, decode).
interface ifu_pcgen_if;
   logic        bmu_vld;
   logic        ifetch_taken;
   logic [63:0] ifetch_taken_pc;

   logic        imem_req_vld;
   logic        imem_req_rdy;
   logic [63:0] imem_req_addr;

   logic        imem_rsp_vld;
   logic [31:0] imem_rsp_data;

   logic        inst_vld;
   logic        inst_rdy;
   logic [31:0] inst;
   logic [63:0] inst_pc;

   modport master (
      input  bmu_vld, ifetch_taken, ifetch_taken_pc,
      input  imem_req_rdy, imem_rsp_vld, imem_rsp_data, inst_rdy,
      output imem_req_vld, imem_req_addr, inst_vld, inst, inst_pc
   );

   modport slave (
      output bmu_vld, ifetch_taken, ifetch_taken_pc,
      output imem_req_rdy, imem_rsp_vld, imem_rsp_data, inst_rdy,
      input  imem_req_vld, imem_req_addr, inst_vld, inst, inst_pc
   );
endinterface

// File: rtl/ifu_pcgen.sv
// ifu_pcgen
// Fetch PC generator and single-outstanding instruction-fetch controller.
// Owns the fetch PC, issues one request at a time to instruction memory,
// holds each returned instruction for decode, and steers the PC on taken
// branch redirects, discarding wrong-path fetches.
// Ports:
//   clk  : clock, all state on rising edge
//   rst  : synchronous active-high reset
//   bus  : ifu_pcgen_if.master (branch resolution, imem req/rsp, decode handoff)
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | one cycle after reset, no request yet
// REQ   | request valid at req_addr, waiting for imem_req_rdy
// WAIT  | request accepted, waiting for its response
// HOLD  | instruction registered, offered to decode
// KILL  | accepted request is wrong-path, discard its response
module ifu_pcgen #(
   parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
   input  logic         clk,
   input  logic         rst,
   ifu_pcgen_if.master  bus
);

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_REQ  = 3'd1;
   localparam logic [2:0] ST_WAIT = 3'd2;
   localparam logic [2:0] ST_HOLD = 3'd3;
   localparam logic [2:0] ST_KILL = 3'd4;

   localparam logic [63:0] RESET_PC_ALIGNED = RESET_PC & ~64'h3;

   logic [2:0]  state_q, state_d;
   logic [63:0] pc_q, pc_d;
   logic [63:0] req_addr_q, req_addr_d;
   logic        kill_pend_q, kill_pend_d;
   logic [31:0] inst_q, inst_d;
   logic [63:0] inst_pc_q, inst_pc_d;

   logic        redirect;
   logic [63:0] target;
   logic [63:0] pc_seq;

   assign redirect = bus.bmu_vld & bus.ifetch_taken;
   assign target   = bus.ifetch_taken_pc & ~64'h3;
   assign pc_seq   = pc_q + 64'd4;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      req_addr_d  = req_addr_q;
      kill_pend_d = kill_pend_q;
      inst_d      = inst_q;
      inst_pc_d   = inst_pc_q;

      case (state_q)
         ST_IDLE: begin
            state_d = ST_REQ;
         end

         ST_REQ: begin
            // A redirect before acceptance cannot retract the request; the
            // stale fetch is remembered and discarded once it completes.
            if (redirect) begin
               pc_d = target;
            end
            kill_pend_d = kill_pend_q | redirect;
            if (bus.imem_req_rdy) begin
               state_d = (kill_pend_q | redirect) ? ST_KILL : ST_WAIT;
            end
         end

         ST_WAIT: begin
            if (redirect) begin
               pc_d = target;
               if (bus.imem_rsp_vld) begin
                  state_d = ST_REQ;
               end else begin
                  state_d     = ST_KILL;
                  kill_pend_d = 1'b1;
               end
            end else if (bus.imem_rsp_vld) begin
               inst_d    = bus.imem_rsp_data;
               inst_pc_d = pc_q;
               pc_d      = pc_seq;
               state_d   = ST_HOLD;
            end
         end

         ST_KILL: begin
            if (redirect) begin
               pc_d = target;
            end
            if (bus.imem_rsp_vld) begin
               kill_pend_d = 1'b0;
               state_d     = ST_REQ;
            end
         end

         ST_HOLD: begin
            if (redirect) begin
               pc_d    = target;
               state_d = ST_REQ;
            end else if (bus.inst_rdy) begin
               state_d = ST_REQ;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // The request address is latched on entry to REQ so that a redirect
      // while the request is stalled does not disturb the offered address.
      if ((state_d == ST_REQ) && (state_q != ST_REQ)) begin
         req_addr_d = pc_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         pc_q        <= RESET_PC_ALIGNED;
         req_addr_q  <= RESET_PC_ALIGNED;
         kill_pend_q <= 1'b0;
         inst_q      <= 32'd0;
         inst_pc_q   <= 64'd0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         req_addr_q  <= req_addr_d;
         kill_pend_q <= kill_pend_d;
         inst_q      <= inst_d;
         inst_pc_q   <= inst_pc_d;
      end
   end

   assign bus.imem_req_vld  = (state_q == ST_REQ);
   assign bus.imem_req_addr = req_addr_q;
   // Masked in a redirect cycle so decode never takes a wrong-path instruction.
   assign bus.inst_vld      = (state_q == ST_HOLD) & ~redirect;
   assign bus.inst          = inst_q;
   assign bus.inst_pc       = inst_pc_q;

endmodule

// File: doc/ifu_pcgen.md
# ifu_pcgen

Fetch-side PC generator and instruction-fetch controller. It owns the architectural fetch PC, issues single-outstanding requests to instruction memory, and holds each returned instruction in an output register for decode. It consumes the execute-stage branch resolution outputs (`ifetch_taken`, `ifetch_taken_pc`, `bmu_vld`), steers the PC on a taken redirect, and discards wrong-path fetches.

## Interface
- `RESET_PC`, default 64'h8000_0000: PC of the first fetch after reset.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `bmu_vld` in 1: one-cycle pulse, branch resolution valid.
- `ifetch_taken` in 1: resolved direction; qualified by `bmu_vld`.
- `ifetch_taken_pc` in 64: redirect target; qualified by `bmu_vld & ifetch_taken`.
- `imem_req_vld` out 1: fetch request valid.
- `imem_req_rdy` in 1: memory accepts request.
- `imem_req_addr` out 64: fetch address, bits [1:0] always 0.
- `imem_rsp_vld` in 1: response valid, at most one per accepted request, no backpressure.
- `imem_rsp_data` in 32: fetched instruction.
- `inst_vld` out 1: decode-side instruction valid.
- `inst_rdy` in 1: decode accepts instruction.
- `inst` out 32: held instruction.
- `inst_pc` out 64: PC of held instruction.

## Operation
- `redirect = bmu_vld & ifetch_taken`. Not-taken resolutions (`bmu_vld & ~ifetch_taken`) are ignored.
- Redirect target is `{ifetch_taken_pc[63:2], 2'b00}`. No misalignment exception is raised.
- Sequential PC update: `pc + 4`, 64-bit, wrapping modulo 2^64.
- FSM states:
  - IDLE: post-reset only; goes to REQ next cycle.
  - REQ: `imem_req_vld = 1`, `imem_req_addr = pc`.
  - WAIT: request accepted, awaiting response.
  - HOLD: instruction registered, `inst_vld` offered.
  - KILL: accepted request is wrong-path, awaiting its response to discard.
- REQ:
  - On `imem_req_rdy`, go to WAIT, or to KILL if `kill_pend` is set or redirect is seen in the same cycle.
  - Address and valid stay stable while `~imem_req_rdy`.
  - A redirect while not accepted sets `pc = target` and `kill_pend`. The stale request still completes, then is killed.
- WAIT:
  - `imem_rsp_vld` without redirect: capture `inst <= imem_rsp_data`, `inst_pc <= pc`, `pc <= pc + 4`, go to HOLD.
  - Redirect without rsp: `pc = target`, go to KILL.
  - Redirect with rsp in the same cycle: drop the response, `pc = target`, go to REQ.
- KILL:
  - On `imem_rsp_vld`, drop the data, clear `kill_pend`, go to REQ.
  - A redirect here overwrites `pc` with the newer target; stay in KILL.
  - Redirect and rsp in the same cycle: drop the rsp, go to REQ with the newer target.
- HOLD:
  - `inst_vld = (state==HOLD) & ~redirect`, combinationally masked, so no handshake occurs in a redirect cycle.
  - `inst_vld & inst_rdy`: go to REQ.
  - Redirect: drop the held instruction, `pc = target`, go to REQ.
- Redirect priority: redirect beats every other event in the same cycle. The last redirect seen always wins.
- At most one request outstanding; a new request is never issued from KILL or WAIT.

## Timing
- Reset values:
  - `imem_req_vld` 0, `imem_req_addr` RESET_PC.
  - `inst_vld` 0, `inst` 0, `inst_pc` 0.
  - `pc` RESET_PC, `kill_pend` 0, state IDLE.
- Reset asserted mid-operation: all state returns to reset values next edge. A response returning after reset deassertion is not allowed by the memory contract and need not be handled.
- First request: `imem_req_vld` high on the 2nd cycle after `rst` falls (IDLE 1 cycle).
- With zero-wait memory (rdy=1, rsp one cycle after accept) and `inst_rdy=1`, the per-instruction sequence is:
  - REQ (accept), WAIT (rsp), HOLD (handshake), REQ.
  - Throughput is one instruction per 3 cycles.
- Redirect to new request: the request at the target is issued the cycle after redirect if from WAIT+rsp, HOLD, or KILL+rsp. Otherwise it is issued the cycle after the killed response.
- `inst`/`inst_pc` remain stable while `inst_vld & ~inst_rdy`.

## Test plan
- Reset, rdy=1, 1-cycle memory, `inst_rdy=1` → requests at 0x8000_0000, 0x8000_0004, 0x8000_0008, with `inst_pc` matching and one `inst_vld` pulse per 3 cycles.
- `inst_rdy` held low 5 cycles in HOLD → `inst`/`inst_pc` stable and no new request; 1 cycle after `inst_rdy` rises, request at `inst_pc+4`.
- Redirect to 0x8000_1002 in WAIT with no rsp → KILL; the next rsp is discarded and the following request address is 0x8000_1000.
- Redirect in REQ with `imem_req_rdy=0` for 3 cycles → `imem_req_addr` is held old; after accept, the rsp is dropped, then a request at the target.
- Redirect in HOLD with `inst_rdy=1` the same cycle → `inst_vld` low that cycle, no handshake, request at target next cycle.
- Two redirects (0x100, then 0x200) during KILL, PC at 0xFFFF_FFFF_FFFF_FFFC then sequential → request at 0x200; a separate run wraps fetch to 0x0.
